// File: rtl/suprloco_vram_arbiter.sv
// ---------------------------------------------------------------------------
// suprloco_vram_arbiter
//
// Shares one single-port video SRAM between the video fetch engine and the
// CPU. Every access is three clock edges long: issue (strobe registered out),
// SRAM cycle (strobe dropped, SRAM presents data), capture (data registered,
// completion pulse). Video requests strictly win over CPU requests, but an
// access already in flight always runs to completion.
//
// Parameters
//   AW             SRAM address width
//   DW             SRAM data width
//
// Ports
//   i_MCLK         master clock, all state changes on rising edge
//   i_RST_n        asynchronous active-low reset
//   i_VID_REQ      one-cycle video read request strobe
//   i_VID_ADDR     video read address, sampled with i_VID_REQ
//   o_VID_DATA     video read data (registered)
//   o_VID_VALID    one-cycle pulse when o_VID_DATA is updated
//   o_VID_OVR      sticky flag: a video request was overwritten before service
//   i_CPU_RQ       CPU access request level, held until o_CPU_ACK
//   i_CPU_WE       1 = write, 0 = read; stable while i_CPU_RQ is high
//   i_CPU_ADDR     CPU address
//   i_CPU_DIN      CPU write data
//   o_CPU_DOUT     CPU read data (registered)
//   o_CPU_ACK      one-cycle completion pulse for reads and writes
//   o_SRAM_ADDR    registered SRAM address
//   o_SRAM_DIN     registered SRAM write data
//   o_SRAM_RD      registered SRAM read strobe
//   o_SRAM_WR      registered SRAM write strobe (never high with o_SRAM_RD)
//   i_SRAM_DOUT    SRAM read data, valid the cycle after RD is sampled
//   o_CPU_WAIT_n   (only with SUPRLOCO_ARB_CPU_WAIT_EN) low while a CPU
//                  request is outstanding and has not reached its capture cycle
//
// Build option
//   SUPRLOCO_ARB_CPU_WAIT_EN  adds the o_CPU_WAIT_n output; when undefined the
//                             port is absent and behaviour is otherwise equal.
// ---------------------------------------------------------------------------

module suprloco_vram_arbiter #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 8
) (
  input  logic          i_MCLK,
  input  logic          i_RST_n,
  // Video port
  input  logic          i_VID_REQ,
  input  logic [AW-1:0] i_VID_ADDR,
  output logic [DW-1:0] o_VID_DATA,
  output logic          o_VID_VALID,
  output logic          o_VID_OVR,
  // CPU port
  input  logic          i_CPU_RQ,
  input  logic          i_CPU_WE,
  input  logic [AW-1:0] i_CPU_ADDR,
  input  logic [DW-1:0] i_CPU_DIN,
  output logic [DW-1:0] o_CPU_DOUT,
  output logic          o_CPU_ACK,
  // SRAM port
  output logic [AW-1:0] o_SRAM_ADDR,
  output logic [DW-1:0] o_SRAM_DIN,
  output logic          o_SRAM_RD,
  output logic          o_SRAM_WR,
  input  logic [DW-1:0] i_SRAM_DOUT
`ifdef SUPRLOCO_ARB_CPU_WAIT_EN
  ,
  output logic          o_CPU_WAIT_n
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StVIss,
    StVCap,
    StCIss,
    StCCap
  } state_e;

  state_e        state_q;
  logic          vid_pend_q;   // a video request is waiting for the arbiter
  logic [AW-1:0] vid_addr_q;   // address of the most recent video request
  logic          cpu_armed_q;  // CPU may start one access for the current RQ
  logic          cpu_we_q;     // direction of the CPU access in flight

  // Video has priority: either a latched request or one arriving this cycle.
  logic          vid_take;
  logic [AW-1:0] vid_take_addr;
  logic          cpu_take;

  always_comb begin
    vid_take      = vid_pend_q | i_VID_REQ;
    // A fresh strobe overrides whatever was latched earlier.
    vid_take_addr = i_VID_REQ ? i_VID_ADDR : vid_addr_q;
    cpu_take      = ~vid_take & i_CPU_RQ & cpu_armed_q;
  end

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q     <= StIdle;
      vid_pend_q  <= 1'b0;
      vid_addr_q  <= '0;
      cpu_armed_q <= 1'b1;
      cpu_we_q    <= 1'b0;
      o_VID_DATA  <= '0;
      o_VID_VALID <= 1'b0;
      o_VID_OVR   <= 1'b0;
      o_CPU_DOUT  <= '0;
      o_CPU_ACK   <= 1'b0;
      o_SRAM_ADDR <= '0;
      o_SRAM_DIN  <= '0;
      o_SRAM_RD   <= 1'b0;
      o_SRAM_WR   <= 1'b0;
    end else begin
      // Completion pulses last exactly one cycle.
      o_VID_VALID <= 1'b0;
      o_CPU_ACK   <= 1'b0;

      // One RQ assertion buys one access: re-arm only once RQ is seen low.
      if (!i_CPU_RQ) begin
        cpu_armed_q <= 1'b1;
      end

      // A second request before the first was serviced loses the first one.
      if (i_VID_REQ && vid_pend_q) begin
        o_VID_OVR <= 1'b1;
      end

      // Always latch the newest video address; the pending flag is handled
      // per state because IDLE services the request on the same edge.
      if (i_VID_REQ) begin
        vid_addr_q <= i_VID_ADDR;
      end

      unique case (state_q)
        StIdle: begin
          if (vid_take) begin
            o_SRAM_ADDR <= vid_take_addr;
            o_SRAM_RD   <= 1'b1;
            o_SRAM_WR   <= 1'b0;
            vid_pend_q  <= 1'b0;
            state_q     <= StVIss;
          end else if (cpu_take) begin
            o_SRAM_ADDR <= i_CPU_ADDR;
            o_SRAM_RD   <= ~i_CPU_WE;
            o_SRAM_WR   <= i_CPU_WE;
            if (i_CPU_WE) begin
              o_SRAM_DIN <= i_CPU_DIN;
            end
            cpu_we_q    <= i_CPU_WE;
            cpu_armed_q <= 1'b0;
            state_q     <= StCIss;
          end
        end

        StVIss: begin
          o_SRAM_RD <= 1'b0;
          o_SRAM_WR <= 1'b0;
          if (i_VID_REQ) begin
            vid_pend_q <= 1'b1;
          end
          state_q <= StVCap;
        end

        StVCap: begin
          o_VID_DATA  <= i_SRAM_DOUT;
          o_VID_VALID <= 1'b1;
          if (i_VID_REQ) begin
            vid_pend_q <= 1'b1;
          end
          state_q <= StIdle;
        end

        StCIss: begin
          o_SRAM_RD <= 1'b0;
          o_SRAM_WR <= 1'b0;
          if (i_VID_REQ) begin
            vid_pend_q <= 1'b1;
          end
          state_q <= StCCap;
        end

        StCCap: begin
          if (!cpu_we_q) begin
            o_CPU_DOUT <= i_SRAM_DOUT;
          end
          o_CPU_ACK <= 1'b1;
          if (i_VID_REQ) begin
            vid_pend_q <= 1'b1;
          end
          state_q <= StIdle;
        end

        default: begin
          o_SRAM_RD <= 1'b0;
          o_SRAM_WR <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

`ifdef SUPRLOCO_ARB_CPU_WAIT_EN
  // Stall the CPU from RQ rise until the capture cycle. While armed the request
  // has not been accepted yet; in StCIss it has been accepted (armed already
  // cleared) but data is not back. Reset forces the output high.
  logic cpu_stall;

  always_comb begin
    cpu_stall    = i_CPU_RQ & (cpu_armed_q | (state_q == StCIss));
    o_CPU_WAIT_n = ~i_RST_n | ~cpu_stall;
  end
`endif

endmodule
